// File: rtl/countdown_timer.sv
// countdown_timer: loadable tick-driven down-counter with a one-cycle Done pulse at zero.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode (DONE reloads the last start value).
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Load_Valid,
    output logic             Load_Ready,
    input  logic [WIDTH-1:0] Load_Value,
    input  logic             Tick,
    input  logic             Abort,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] count_nx, dec;
    logic load;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_nx;
    assign reload_nx = load ? Load_Value : reload;
`endif
    assign dec        = Count - WIDTH'(1);
    assign Load_Ready = state == IDLE;
    assign Busy       = state != IDLE;
    assign Done       = state == DONE;
    assign load       = Load_Valid && Load_Ready;
    always_comb begin
        state_nx = state;
        count_nx = Count;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = Load_Value != '0 ? COUNT : DONE;
                    count_nx = Load_Value;
                end
            end
            COUNT: begin
                if (Abort) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else if (Tick) begin
                    state_nx = Count == WIDTH'(1) ? DONE : COUNT;
                    count_nx = dec;
                end
            end
            DONE: begin
                state_nx = IDLE;
                count_nx = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                // a zero reload would pulse Done forever, so it falls back to idle
                if (!Abort && reload != '0) begin
                    state_nx = COUNT;
                    count_nx = reload;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            Count <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state <= state_nx;
            Count <= count_nx;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= reload_nx;
`endif
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus, cycle-level reference model plus literal checks.
module tb_countdown_timer;
    logic       clk = 0;
    logic       rst = 1;
    logic       Load_Valid = 0;
    logic       Load_Ready;
    logic [7:0] Load_Value = 0;
    logic       Tick = 0;
    logic       Abort = 0;
    logic [7:0] Count;
    logic       Busy;
    logic       Done;
    int total = 0;
    int bad = 0;

    countdown_timer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .Load_Valid(Load_Valid), .Load_Ready(Load_Ready),
        .Load_Value(Load_Value), .Tick(Tick), .Abort(Abort),
        .Count(Count), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining ticks, whether a run is active, and whether this is the pulse cycle.
    int  m_cnt = 0;
    int  m_rel = 0;
    bit  m_run = 0;
    bit  m_pulse = 0;
    bit  m_ok = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_rel = 0; m_run = 0; m_pulse = 0; m_ok = 1;
        end else if (m_pulse) begin
            m_pulse = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (!Abort && m_rel != 0) begin
                m_cnt = m_rel;
                m_run = 1;
            end
`endif
        end else if (m_run) begin
            if (Abort) begin
                m_run = 0;
                m_cnt = 0;
            end else if (Tick) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_run = 0;
                    m_pulse = 1;
                end
            end
        end else if (Load_Valid) begin
            m_rel   = int'(Load_Value);
            m_cnt   = int'(Load_Value);
            m_run   = Load_Value != 0;
            m_pulse = Load_Value == 0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_count", int'(Count), m_cnt);
            chk("model_busy", int'(Busy), int'(m_run | m_pulse));
            chk("model_done", int'(Done), int'(m_pulse));
            chk("model_ready", int'(Load_Ready), int'(!(m_run | m_pulse)));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] v);
        Load_Valid = 1;
        Load_Value = v;
        cyc();
        Load_Valid = 0;
    endtask

    task automatic settle();
        Tick = 0;
        Abort = 1;
        cyc();
        Abort = 0;
        cyc();
    endtask

    int done_seen;
    logic [7:0] gate_exp [5] = '{8'h03, 8'h02, 8'h02, 8'h01, 8'h01};

    initial begin
        cyc(2);
        rst = 0;
        chk("rst_count", int'(Count), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_ready", int'(Load_Ready), 1);
        chk("rst_done", int'(Done), 0);

        // reset mid-count at 0x37
        Tick = 1;
        load(8'h40);
        cyc(9);
        chk("pre_rst_count", int'(Count), 'h37);
        rst = 1;
        cyc();
        chk("midrst_count", int'(Count), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_ready", int'(Load_Ready), 1);
        chk("midrst_done", int'(Done), 0);
        cyc();
        rst = 0;

        // one-shot load 5 with Tick high
        Tick = 1;
        load(8'h05);
        for (int i = 0; i < 5; i++) begin
            chk("oneshot_count", int'(Count), 5 - i);
            chk("oneshot_nodone", int'(Done), 0);
            cyc();
        end
        chk("oneshot_done", int'(Done), 1);
        chk("oneshot_zero", int'(Count), 0);
        cyc();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        chk("oneshot_reload", int'(Count), 5);
`else
        chk("oneshot_ready", int'(Load_Ready), 1);
`endif
        chk("oneshot_done_end", int'(Done), 0);
        settle();

        // tick gating 1,0,1,0,1
        load(8'h03);
        for (int i = 0; i < 5; i++) begin
            chk("gate_count", int'(Count), int'(gate_exp[i]));
            chk("gate_nodone", int'(Done), 0);
            Tick = (i % 2) == 0;
            cyc();
        end
        chk("gate_done", int'(Done), 1);
        settle();

        // zero load: Done in the next cycle
        load(8'h00);
        chk("zero_done", int'(Done), 1);
        chk("zero_busy", int'(Busy), 1);
        chk("zero_count", int'(Count), 0);
        cyc();
        chk("zero_ready", int'(Load_Ready), 1);

        // load offered while counting is ignored
        Tick = 0;
        load(8'h10);
        Load_Valid = 1;
        Load_Value = 8'hAA;
        cyc(3);
        Load_Valid = 0;
        chk("ignore_count", int'(Count), 'h10);
        settle();
        chk("ignore_abort_count", int'(Count), 0);

        // abort at 0xF0; no Done afterwards
        Tick = 1;
        load(8'hFF);
        cyc(15);
        chk("abort_pre", int'(Count), 'hF0);
        Abort = 1;
        cyc();
        Abort = 0;
        chk("abort_count", int'(Count), 0);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_ready", int'(Load_Ready), 1);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            done_seen += int'(Done);
            cyc();
        end
        chk("abort_no_done", done_seen, 0);

        // Abort in IDLE does not block a handshake
        Abort = 1;
        load(8'h02);
        Abort = 0;
        chk("idle_abort_count", int'(Count), 2);
        chk("idle_abort_busy", int'(Busy), 1);
        cyc(2);
        chk("idle_abort_done", int'(Done), 1);
        settle();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // periodic: 2,1,0 repeating
        Tick = 1;
        load(8'h02);
        for (int p = 0; p < 3; p++) begin
            chk("auto_c2", int'(Count), 2);
            chk("auto_ready", int'(Load_Ready), 0);
            cyc();
            chk("auto_c1", int'(Count), 1);
            cyc();
            chk("auto_done", int'(Done), 1);
            cyc();
        end
        Abort = 1;
        cyc();
        Abort = 0;
        chk("auto_abort_ready", int'(Load_Ready), 1);
        chk("auto_abort_count", int'(Count), 0);
`endif
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, tick-driven down-counter that wraps the team's 8-bit decrement stage in sequential control. It accepts a start value over a valid/ready handshake, decrements once per qualifying `Tick`, and emits a one-cycle `Done` pulse when the count reaches zero. It sits directly downstream of the combinational decrementer and registers that stage's result every enabled cycle.

## Interface
Parameters:
- `WIDTH`, 8, counter and load-value width (≥2).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Load_Valid`  in  1  start value offered.
- `Load_Ready`  out  1  timer can accept a start value.
- `Load_Value`  in  WIDTH  start count.
- `Tick`  in  1  decrement enable (prescaler strobe or tie high).
- `Abort`  in  1  cancel counting, return to idle.
- `Count`  out  WIDTH  current registered count.
- `Busy`  out  1  high in COUNT and DONE states.
- `Done`  out  1  one-cycle pulse on reaching zero.

## Operation
- States: IDLE, COUNT, DONE (registered; encoding free).
- Reset (`rst`=1 at edge): state IDLE, `Count`=0, `Done`=0, `Busy`=0, `Load_Ready`=1, internal reload register=0.
- `Load_Ready` = 1 only in IDLE (combinational from state). Handshake fires when `Load_Valid` && `Load_Ready`.
- IDLE: on handshake with `Load_Value`≠0 → COUNT, `Count`←`Load_Value`; with `Load_Value`=0 → DONE, `Count`←0. Reload register ← `Load_Value` on every handshake. No handshake: hold.
- COUNT: `Tick`=1 → `Count`←`Count`−1 (modulo 2^WIDTH, same arithmetic as the decrement stage). If `Count`=1 and `Tick`=1 → DONE next cycle with `Count`=0. `Tick`=0 → hold.
- DONE: `Done`=1 for exactly this one cycle; next state IDLE (see Configuration).
- `Abort`=1 in COUNT or DONE → IDLE next cycle, `Count`←0, no `Done` pulse issued afterward. `Abort` in IDLE: ignored, and handshake in the same cycle still proceeds.
- Priority: `rst` > `Abort` > `Tick`/terminal logic.
- `Load_Valid` outside IDLE is ignored; no value buffered.
- `Count` never underflows past 0 in COUNT; wrap only reachable via the arithmetic rule, which the FSM guards.

## Timing
- Handshake at edge N → `Count`=`Load_Value`, `Busy`=1 in cycle N+1.
- With `Tick` tied high and load value V≥1: `Done`=1 in cycle N+V+1 (V decrements, then DONE); `Load_Ready`=1 again in cycle N+V+2.
- Load value 0: `Done`=1 in cycle N+1.
- `Done`, `Busy`, `Count` are registered or decoded from registered state only; no combinational path from inputs to outputs except none — `Load_Ready` depends on state only.
- Reset mid-count: outputs take reset values at the first edge with `rst`=1.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined: DONE → COUNT with `Count`←reload register (periodic mode, period V+1 cycles with `Tick` high); `Done` still pulses once per period; `Load_Ready` stays 0 until `Abort`. If reload register is 0, DONE → IDLE (no continuous `Done`).
- Undefined: DONE → IDLE always; reload register may be omitted.

## Test plan
- Reset: assert `rst` 2 cycles mid-count at `Count`=0x37 → `Count`=0, `Busy`=0, `Load_Ready`=1, `Done`=0 next cycle.
- One-shot: load 0x05, `Tick`=1 → `Count` 5,4,3,2,1,0, `Done` high exactly in cycle N+6, `Load_Ready`=1 in cycle N+7.
- Tick gating: load 0x03, `Tick` toggling 1,0,1,0,… → `Count` holds on `Tick`=0 cycles; `Done` at cycle N+6.
- Zero load and ignored load: load 0x00 → `Done` at N+1; drive `Load_Valid` with 0xAA during COUNT → no change to `Count`.
- Abort: load 0xFF, `Abort` at `Count`=0xF0 → IDLE next cycle, `Count`=0, no `Done` ever.
- Auto-reload (macro defined): load 0x02, `Tick`=1 → `Done` every 3 cycles, `Count` 2,1,0,2,1,0…; `Abort` stops it.
